// File: rtl/approx_err_stats_8x8.sv
// Error statistics for an 8x8 approximate multiplier under test: the exact product is recomputed in a
// 3-stage pipeline, and the error count, the saturating error-distance sum and the worst case are accumulated over N_SAMPLES samples.
module approx_err_stats_8x8 #(
  parameter int unsigned N_SAMPLES = 65536,
  parameter int unsigned SUM_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic [15:0]      R,
  output logic             busy,
  output logic             done,
  output logic [16:0]      n_err,
  output logic [SUM_W-1:0] sum_ed,
  output logic [15:0]      max_ed,
  output logic [7:0]       max_a,
  output logic [7:0]       max_b
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [16:0] N_LAST = 17'(N_SAMPLES);

  state_t            state_reg;
  logic [16:0]       cnt_reg;
  logic              busy_reg, done_reg;

  logic              s1_valid_reg;
  logic [7:0]        s1_a_reg, s1_b_reg;
  logic [15:0]       s1_r_reg;

  logic              s2_valid_reg, s2_err_reg;
  logic [15:0]       s2_ed_reg;
  logic [7:0]        s2_a_reg, s2_b_reg;

  logic [16:0]       n_err_reg;
  logic [SUM_W-1:0]  sum_ed_reg;
  logic [15:0]       max_ed_reg;
  logic [7:0]        max_a_reg, max_b_reg;

  logic              accept;
  logic              start_go;
  logic [15:0]       prod;
  logic [15:0]       ed;
  logic [SUM_W:0]    sum_wide;

  assign in_ready = (state_reg == RUN);
  assign accept   = in_valid && in_ready;
  assign start_go = start && ((state_reg == IDLE) || (state_reg == DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            cnt_reg <= cnt_reg + 17'd1;
            if (cnt_reg + 17'd1 == N_LAST)
              state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          // Finish only once the last accepted sample has reached the accumulators.
          if (!s1_valid_reg && !s2_valid_reg) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Stage 1: capture the accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_r_reg     <= '0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_a_reg <= A;
        s1_b_reg <= B;
        s1_r_reg <= R;
      end
    end
  end

  // Stage 2: exact product and absolute error distance.
  assign prod = 16'(s1_a_reg) * 16'(s1_b_reg);
  assign ed   = (prod >= s1_r_reg) ? (prod - s1_r_reg) : (s1_r_reg - prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_err_reg   <= 1'b0;
      s2_ed_reg    <= '0;
      s2_a_reg     <= '0;
      s2_b_reg     <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_err_reg <= (ed != 16'd0);
        s2_ed_reg  <= ed;
        s2_a_reg   <= s1_a_reg;
        s2_b_reg   <= s1_b_reg;
      end
    end
  end

  // Stage 3: accumulate; one extra sum bit exposes the overflow used for clamping.
  assign sum_wide = {1'b0, sum_ed_reg} + (SUM_W+1)'(s2_ed_reg);

  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      n_err_reg  <= '0;
      sum_ed_reg <= '0;
      max_ed_reg <= '0;
      max_a_reg  <= '0;
      max_b_reg  <= '0;
    end else if (s2_valid_reg) begin
      n_err_reg  <= n_err_reg + 17'(s2_err_reg);
      sum_ed_reg <= sum_wide[SUM_W] ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
      if (s2_ed_reg > max_ed_reg) begin
        max_ed_reg <= s2_ed_reg;
        max_a_reg  <= s2_a_reg;
        max_b_reg  <= s2_b_reg;
      end
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign n_err  = n_err_reg;
  assign sum_ed = sum_ed_reg;
  assign max_ed = max_ed_reg;
  assign max_a  = max_a_reg;
  assign max_b  = max_b_reg;

endmodule

// File: tb/tb_approx_err_stats_8x8.sv
// Bench for approx_err_stats_8x8: three parameterisations driven with directed and random runs,
// each checked against a plain-arithmetic model of the error statistics.
module tb_approx_err_stats_8x8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  A, B;
  logic [15:0] R;
  logic        start4, start3, start256;

  logic        rdy4, busy4, done4;
  logic [16:0] nerr4;
  logic [16:0] sum4;
  logic [15:0] max4;
  logic [7:0]  ma4, mb4;

  logic        rdy3, busy3, done3;
  logic [16:0] nerr3;
  logic [31:0] sum3;
  logic [15:0] max3;
  logic [7:0]  ma3, mb3;

  logic        rdy256, busy256, done256;
  logic [16:0] nerr256;
  logic [31:0] sum256;
  logic [15:0] max256;
  logic [7:0]  ma256, mb256;

  always #5 clk = ~clk;

  approx_err_stats_8x8 #(.N_SAMPLES(4), .SUM_W(17)) u4 (
    .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid), .in_ready(rdy4),
    .A(A), .B(B), .R(R), .busy(busy4), .done(done4), .n_err(nerr4),
    .sum_ed(sum4), .max_ed(max4), .max_a(ma4), .max_b(mb4));

  approx_err_stats_8x8 #(.N_SAMPLES(3), .SUM_W(32)) u3 (
    .clk(clk), .rst(rst), .start(start3), .in_valid(in_valid), .in_ready(rdy3),
    .A(A), .B(B), .R(R), .busy(busy3), .done(done3), .n_err(nerr3),
    .sum_ed(sum3), .max_ed(max3), .max_a(ma3), .max_b(mb3));

  approx_err_stats_8x8 #(.N_SAMPLES(256), .SUM_W(32)) u256 (
    .clk(clk), .rst(rst), .start(start256), .in_valid(in_valid), .in_ready(rdy256),
    .A(A), .B(B), .R(R), .busy(busy256), .done(done256), .n_err(nerr256),
    .sum_ed(sum256), .max_ed(max256), .max_a(ma256), .max_b(mb256));

  int sel;
  logic [31:0] o_rdy, o_busy, o_done, o_nerr, o_sum, o_max, o_ma, o_mb;

  always_comb begin
    o_rdy = '0; o_busy = '0; o_done = '0; o_nerr = '0;
    o_sum = '0; o_max = '0; o_ma = '0; o_mb = '0;
    case (sel)
      0: begin
        o_rdy = 32'(rdy4); o_busy = 32'(busy4); o_done = 32'(done4); o_nerr = 32'(nerr4);
        o_sum = 32'(sum4); o_max = 32'(max4); o_ma = 32'(ma4); o_mb = 32'(mb4);
      end
      1: begin
        o_rdy = 32'(rdy3); o_busy = 32'(busy3); o_done = 32'(done3); o_nerr = 32'(nerr3);
        o_sum = sum3; o_max = 32'(max3); o_ma = 32'(ma3); o_mb = 32'(mb3);
      end
      default: begin
        o_rdy = 32'(rdy256); o_busy = 32'(busy256); o_done = 32'(done256); o_nerr = 32'(nerr256);
        o_sum = sum256; o_max = 32'(max256); o_ma = 32'(ma256); o_mb = 32'(mb256);
      end
    endcase
  end

  int checks = 0;
  int passes = 0;
  int qa[$], qb[$], qr[$], pat[$];
  int exp_nerr, exp_max, exp_ma, exp_mb;
  longint exp_sum;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      0: start4 = v;
      1: start3 = v;
      default: start256 = v;
    endcase
  endtask

  task automatic push(input int a, input int b, input int r);
    qa.push_back(a); qb.push_back(b); qr.push_back(r);
  endtask

  task automatic clear_q();
    qa.delete(); qb.delete(); qr.delete(); pat.delete();
  endtask

  // Reference: statistics straight from the definition of error distance.
  task automatic model(input int sw);
    longint cap, p, ed;
    cap = (longint'(1) << sw) - 1;
    exp_nerr = 0; exp_sum = 0; exp_max = 0; exp_ma = 0; exp_mb = 0;
    foreach (qa[i]) begin
      p  = longint'(qa[i]) * longint'(qb[i]);
      ed = (p > qr[i]) ? p - qr[i] : qr[i] - p;
      if (ed != 0) exp_nerr++;
      exp_sum = exp_sum + ed;
      if (exp_sum > cap) exp_sum = cap;
      if (ed > exp_max) begin
        exp_max = int'(ed); exp_ma = qa[i]; exp_mb = qb[i];
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rdy"},  o_rdy,  0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_nerr"}, o_nerr, 0);
    chk({tag, "_sum"},  o_sum,  0);
    chk({tag, "_max"},  o_max,  0);
    chk({tag, "_ma"},   o_ma,   0);
    chk({tag, "_mb"},   o_mb,   0);
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_nerr"}, o_nerr, 32'(exp_nerr));
    chk({tag, "_sum"},  o_sum,  32'(exp_sum));
    chk({tag, "_max"},  o_max,  32'(exp_max));
    chk({tag, "_ma"},   o_ma,   32'(exp_ma));
    chk({tag, "_mb"},   o_mb,   32'(exp_mb));
  endtask

  // One full run: start, feed the queued samples (pattern first, then random gaps), drain, verify.
  task automatic do_run(input string tag, input int which, input int sw, input int gap_pct,
                        input bit pokes);
    int idx;
    bit v;
    sel = which;
    model(sw);
    in_valid = 1'b0;
    set_start(which, 1'b1);
    tick();
    set_start(which, 1'b0);
    chk({tag, "_start_busy"}, o_busy, 1);
    chk({tag, "_start_rdy"},  o_rdy,  1);
    chk({tag, "_start_done"}, o_done, 0);
    chk({tag, "_start_clr"},  o_nerr | o_sum | o_max, 0);
    idx = 0;
    while (idx < qa.size()) begin
      if (pat.size() > 0) v = (pat.pop_front() != 0);
      else v = ($urandom_range(99) >= gap_pct);
      if (v) begin
        in_valid = 1'b1; A = 8'(qa[idx]); B = 8'(qb[idx]); R = 16'(qr[idx]);
        idx++;
      end else begin
        in_valid = 1'b0; A = 8'($urandom); B = 8'($urandom); R = 16'($urandom);
        if (pokes) set_start(which, 1'b1);
      end
      tick();
      set_start(which, 1'b0);
    end
    in_valid = 1'b0;
    chk({tag, "_drain_rdy"},  o_rdy,  0);
    chk({tag, "_drain_busy"}, o_busy, 1);
    tick();
    chk({tag, "_drain1_done"}, o_done, 0);
    tick();
    chk({tag, "_drain2_done"}, o_done, 0);
    if (pokes) set_start(which, 1'b1);
    tick();
    set_start(which, 1'b0);
    chk({tag, "_done"},      o_done, 1);
    chk({tag, "_done_busy"}, o_busy, 0);
    chk({tag, "_done_rdy"},  o_rdy,  0);
    check_stats(tag);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; A = 8'($urandom); B = 8'($urandom); R = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk({tag, "_hold_nerr"}, o_nerr, 32'(exp_nerr));
    chk({tag, "_hold_sum"},  o_sum,  32'(exp_sum));
    chk({tag, "_hold_done"}, o_done, 1);
    $display("run %s: samples=%0d n_err=%0d sum_ed=%0d max_ed=%0d max_a=%0d max_b=%0d",
             tag, qa.size(), o_nerr, o_sum, o_max, o_ma, o_mb);
  endtask

  initial begin
    int a, b, p, r, m;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; R = '0;
    start4 = 1'b0; start3 = 1'b0; start256 = 1'b0; sel = 0;
    repeat (3) tick();
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check_zero($sformatf("reset%0d", s));
    end

    clear_q();
    push(3, 5, 15); push(3, 5, 14); push(255, 255, 65000); push(2, 2, 5);
    do_run("basic", 0, 17, 0, 1'b0);

    clear_q();
    push(1, 1, 3); push(2, 1, 0); push(4, 4, 16); push(0, 9, 0);
    do_run("tie", 0, 17, 0, 1'b0);

    clear_q();
    for (int i = 0; i < 4; i++) push(255, 255, 0);
    do_run("sat", 0, 17, 0, 1'b0);

    clear_q();
    push(7, 9, 60); push(200, 3, 600); push(17, 17, 300);
    pat = '{1, 0, 0, 1, 0, 1};
    do_run("gaps", 1, 32, 0, 1'b1);

    // Reset in the middle of a run, two samples already in the pipeline.
    sel = 0;
    start4 = 1'b1; tick(); start4 = 1'b0;
    in_valid = 1'b1; A = 8'd255; B = 8'd255; R = 16'd0; tick();
    A = 8'd100; B = 8'd100; R = 16'd1; tick();
    in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    check_zero("midrst");
    tick();
    check_zero("midrst_idle");
    clear_q();
    push(10, 10, 90); push(5, 6, 30); push(8, 8, 70); push(1, 1, 1);
    do_run("after_rst", 0, 17, 0, 1'b0);

    clear_q();
    for (int i = 0; i < 256; i++) begin
      a = int'($urandom_range(255)); b = int'($urandom_range(255));
      push(a, b, a * b);
    end
    do_run("exact", 2, 32, 20, 1'b0);

    for (int run = 0; run < 3; run++) begin
      clear_q();
      for (int i = 0; i < 256; i++) begin
        a = int'($urandom_range(255)); b = int'($urandom_range(255)); p = a * b;
        m = int'($urandom_range(3));
        if (m == 0) r = p;
        else if (m == 1) r = int'($urandom_range(65535));
        else begin
          r = p + int'($urandom_range(40)) - 20;
          if (r < 0) r = 0;
          if (r > 65535) r = 65535;
        end
        push(a, b, r);
      end
      do_run($sformatf("rand256_%0d", run), 2, 32, 25, 1'b0);
    end

    for (int run = 0; run < 4; run++) begin
      clear_q();
      for (int i = 0; i < 3; i++) begin
        a = int'($urandom_range(255)); b = int'($urandom_range(255));
        push(a, b, int'($urandom_range(65535)));
      end
      do_run($sformatf("rand3_%0d", run), 1, 32, 40, 1'b1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
